// File: rtl/key_debouncer.sv
// Three-channel pushbutton conditioner for the DE2 KEY[3:1] inputs: synchronise, debounce,
// and emit registered press/release/long-press pulses, a held level and a press counter.
module key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LONG_CYCLES     = 50000000,
  parameter int CNT_W           = 26
) (
  input  logic       CLOCK_50,
  input  logic [3:0] KEY,
  output logic [2:0] held,
  output logic [2:0] press_pulse,
  output logic [2:0] release_pulse,
  output logic [2:0] long_press,
  output logic [7:0] press_count,
  output logic [5:0] state_dbg
);

  // Handshake: none. KEY is a raw asynchronous level; every output is a registered
  // level or a one-cycle pulse, with no valid/ready pairing anywhere in this block.

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] D_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_MAX  = CNT_W'(LONG_CYCLES);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic rst_n;
  assign rst_n = KEY[0];

  logic [2:0] sync1, sync2;

  state_t           st    [3];
  state_t           st_nx [3];
  logic [CNT_W-1:0] dcnt    [3];
  logic [CNT_W-1:0] dcnt_nx [3];
  logic [CNT_W-1:0] hcnt    [3];
  logic [CNT_W-1:0] hcnt_nx [3];
  logic [2:0]       press_nx, rel_nx, long_nx, held_nx;

  function automatic logic [7:0] pop3(input logic [2:0] v);
    return {7'd0, v[0]} + {7'd0, v[1]} + {7'd0, v[2]};
  endfunction

  // Both synchroniser flops reset to 1 so a reset looks like "all keys released".
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 3'b111;
      sync2 <= 3'b111;
    end else begin
      sync1 <= KEY[3:1];
      sync2 <= sync1;
    end
  end

  always_comb begin
    press_nx = '0;
    rel_nx   = '0;
    long_nx  = '0;
    held_nx  = '0;
    for (int i = 0; i < 3; i++) begin
      st_nx[i]   = st[i];
      dcnt_nx[i] = dcnt[i];
      hcnt_nx[i] = hcnt[i];
      // The hold counter runs through release qualification so long_press can still fire there.
      if ((st[i] == PRESSED || st[i] == RELEASE_WAIT) && hcnt[i] != LONG_MAX) begin
        hcnt_nx[i] = hcnt[i] + CNT_ONE;
        long_nx[i] = (hcnt[i] == LONG_LAST);
      end
      case (st[i])
        RELEASED: begin
          if (!sync2[i]) begin
            st_nx[i]   = PRESS_WAIT;
            dcnt_nx[i] = '0;
          end
        end
        PRESS_WAIT: begin
          if (sync2[i]) begin
            st_nx[i] = RELEASED;
          end else if (dcnt[i] == D_LAST) begin
            st_nx[i]    = PRESSED;
            press_nx[i] = 1'b1;
            hcnt_nx[i]  = '0;
          end else begin
            dcnt_nx[i] = dcnt[i] + CNT_ONE;
          end
        end
        PRESSED: begin
          if (sync2[i]) begin
            st_nx[i]   = RELEASE_WAIT;
            dcnt_nx[i] = '0;
          end
        end
        RELEASE_WAIT: begin
          if (!sync2[i]) begin
            st_nx[i] = PRESSED;
          end else if (dcnt[i] == D_LAST) begin
            st_nx[i]  = RELEASED;
            rel_nx[i] = 1'b1;
          end else begin
            dcnt_nx[i] = dcnt[i] + CNT_ONE;
          end
        end
        default: st_nx[i] = RELEASED;
      endcase
      held_nx[i] = (st_nx[i] == PRESSED) || (st_nx[i] == RELEASE_WAIT);
    end
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        st[i]   <= RELEASED;
        dcnt[i] <= '0;
        hcnt[i] <= '0;
      end
      held          <= '0;
      press_pulse   <= '0;
      release_pulse <= '0;
      long_press    <= '0;
      press_count   <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        st[i]   <= st_nx[i];
        dcnt[i] <= dcnt_nx[i];
        hcnt[i] <= hcnt_nx[i];
      end
      held          <= held_nx;
      press_pulse   <= press_nx;
      release_pulse <= rel_nx;
      long_press    <= long_nx;
      // Counts the pulses visible this cycle, so the total trails press_pulse by one edge.
      press_count   <= press_count + pop3(press_pulse);
    end
  end

  always_comb begin
    state_dbg = {st[2], st[1], st[0]};
  end

endmodule

// File: tb/tb_key_debouncer.sv
// Directed bench for key_debouncer with DEBOUNCE_CYCLES=4, LONG_CYCLES=20.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_key_debouncer;

  logic       CLOCK_50;
  logic [3:0] KEY;
  logic [2:0] held, press_pulse, release_pulse, long_press;
  logic [7:0] press_count;
  logic [5:0] state_dbg;

  int tests = 0;
  int fails = 0;

  logic [2:0] seen_press, seen_rel, seen_held;
  int         long_cnt;
  logic       held_all;

  key_debouncer #(
    .DEBOUNCE_CYCLES(4),
    .LONG_CYCLES    (20),
    .CNT_W          (8)
  ) dut (
    .CLOCK_50     (CLOCK_50),
    .KEY          (KEY),
    .held         (held),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_press   (long_press),
    .press_count  (press_count),
    .state_dbg    (state_dbg)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_seen();
    seen_press = '0;
    seen_rel   = '0;
    seen_held  = '0;
    long_cnt   = 0;
  endtask

  task automatic step();
    @(posedge CLOCK_50);
    #1;
    seen_press |= press_pulse;
    seen_rel   |= release_pulse;
    seen_held  |= held;
    long_cnt   += int'(long_press[0]) + int'(long_press[1]) + int'(long_press[2]);
  endtask

  task automatic do_reset();
    KEY = 4'b1110;
    step();
    step();
    KEY = 4'b1111;
    step();
    clear_seen();
  endtask

  initial begin
    KEY = 4'b1110;
    clear_seen();
    held_all = 1'b1;

    // Reset held with all keys released
    repeat (3) step();
    check("rst_held", held, 3'b000);
    check("rst_press", press_pulse, 3'b000);
    check("rst_release", release_pulse, 3'b000);
    check("rst_long", long_press, 3'b000);
    check("rst_count", press_count, 8'd0);
    KEY = 4'b1111;
    clear_seen();
    repeat (3) step();
    check("post_rst_held", held, 3'b000);
    check("post_rst_count", press_count, 8'd0);
    check("post_rst_any", {seen_press, seen_rel, seen_held}, 9'd0);

    // Clean press of KEY[1]: pulse after edge 7, released after 10 low samples
    KEY[1] = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k == 6) check("clean_press_early", press_pulse, 3'b000);
      if (k == 6) check("clean_held_early", held, 3'b000);
      if (k == 7) check("clean_press_pulse", press_pulse, 3'b001);
      if (k == 7) check("clean_held_set", held, 3'b001);
      if (k == 8) check("clean_press_width", press_pulse, 3'b000);
      if (k == 8) check("clean_count", press_count, 8'd1);
    end
    KEY[1] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k == 6) check("clean_rel_early", release_pulse, 3'b000);
      if (k == 6) check("clean_held_hold", held, 3'b001);
      if (k == 7) check("clean_rel_pulse", release_pulse, 3'b001);
      if (k == 7) check("clean_held_clr", held, 3'b000);
      if (k == 8) check("clean_rel_width", release_pulse, 3'b000);
    end
    check("clean_no_long", long_cnt, 0);
    check("clean_count_final", press_count, 8'd1);

    // Bounce on KEY[2]: low 2, high 1, low 2, high 5
    do_reset();
    KEY[2] = 1'b0; step(); step();
    KEY[2] = 1'b1; step();
    KEY[2] = 1'b0; step(); step();
    KEY[2] = 1'b1;
    repeat (5) step();
    repeat (4) step();
    check("bounce_press", seen_press, 3'b000);
    check("bounce_release", seen_rel, 3'b000);
    check("bounce_held", seen_held, 3'b000);
    check("bounce_count", press_count, 8'd0);

    // Long press on KEY[3] for 40 cycles
    do_reset();
    KEY[3] = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (k == 7)  check("long_press_pulse", press_pulse, 3'b100);
      if (k == 26) check("long_early", long_press, 3'b000);
      if (k == 27) check("long_fire", long_press, 3'b100);
      if (k == 28) check("long_width", long_press, 3'b000);
      if (k >= 7)  held_all &= held[2];
    end
    KEY[3] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k <= 6) held_all &= held[2];
      if (k == 7) check("long_rel_pulse", release_pulse, 3'b100);
      if (k == 7) check("long_held_clr", held, 3'b000);
    end
    check("long_held_throughout", held_all, 1'b1);
    check("long_once", long_cnt, 1);
    check("long_count", press_count, 8'd1);

    // 254 presses of KEY[1], then all three keys together: 254 + 3 wraps to 1
    do_reset();
    for (int n = 0; n < 254; n++) begin
      KEY[1] = 1'b0;
      repeat (8) step();
      KEY[1] = 1'b1;
      repeat (9) step();
    end
    check("preset_count", press_count, 8'd254);
    KEY[3:1] = 3'b000;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k == 6) check("simul_early", press_pulse, 3'b000);
      if (k == 7) check("simul_pulse", press_pulse, 3'b111);
      if (k == 7) check("simul_held", held, 3'b111);
      if (k == 8) check("simul_wrap_count", press_count, 8'd1);
    end
    KEY[3:1] = 3'b111;
    repeat (10) step();

    // Reset 10 cycles into a KEY[1] press; key still low when reset releases
    do_reset();
    KEY[1] = 1'b0;
    repeat (10) step();
    check("midrst_held_before", held, 3'b001);
    KEY[0] = 1'b0;
    #1;
    check("midrst_held_async", held, 3'b000);
    check("midrst_count_async", press_count, 8'd0);
    clear_seen();
    step();
    step();
    KEY[0] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k == 6) check("midrst_no_early_press", seen_press, 3'b000);
      if (k == 7) check("midrst_fresh_press", press_pulse, 3'b001);
      if (k == 8) check("midrst_count", press_count, 8'd1);
    end
    check("midrst_no_release", seen_rel, 3'b000);
    KEY[1] = 1'b1;
    repeat (10) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/key_debouncer.md
# key_debouncer

Input-side companion to the board's LED drivers. Takes the three DE2 user pushbuttons KEY[3:1] from the 50 MHz board clock domain, synchronises and debounces each one, and produces clean single-cycle press, release and long-press events plus a level "held" flag per key. KEY[0] serves as the board reset. The block sits between the raw pins and the control logic, such as blinkers and mode selectors, that reacts to user input.

## Interface
- DEBOUNCE_CYCLES, 1000000: cycles a new key level must stay stable before it is accepted (20 ms at 50 MHz); legal values are ≥ 2.
- LONG_CYCLES, 50000000: cycles from an accepted press to the long_press event (1 s at 50 MHz); must be greater than DEBOUNCE_CYCLES.
- CNT_W, 26: width of the debounce and hold counters; must hold LONG_CYCLES.
- CLOCK_50, input, 1: the single clock; all logic runs on its rising edge.
- KEY, input, 4: KEY[0] is the asynchronous, active-low reset. KEY[3:1] are the raw buttons, active-low (0 = pressed) and asynchronous to CLOCK_50.
- held, output, 3: held[i-1] is 1 while KEY[i] is in the debounced-pressed condition.
- press_pulse, output, 3: one-cycle pulse when a press is accepted.
- release_pulse, output, 3: one-cycle pulse when a release is accepted.
- long_press, output, 3: one-cycle pulse, at most once per press, after LONG_CYCLES of hold.
- press_count, output, 8: running total of accepted presses on all keys; wraps modulo 256.

## Operation
- Per key, two-flop synchroniser; both flops reset to 1, meaning released.
- Per-key FSM with states RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT. Each key has its own debounce counter dcnt and hold counter hcnt.
- RELEASED: sync==0 → PRESS_WAIT, dcnt=0.
- PRESS_WAIT:
  - sync==1 → RELEASED. This is a bounce and produces no event.
  - sync==0 and dcnt==DEBOUNCE_CYCLES-1 → PRESSED. On the same edge: press_pulse=1, held=1, hcnt=0.
  - Otherwise, dcnt increments.
- PRESSED:
  - hcnt increments and saturates at LONG_CYCLES.
  - The edge on which hcnt goes from LONG_CYCLES-1 to LONG_CYCLES also pulses long_press.
  - sync==1 → RELEASE_WAIT, dcnt=0.
- RELEASE_WAIT:
  - hcnt keeps counting and long_press can still fire here.
  - sync==0 → PRESSED. This is a bounce; hcnt is preserved and there is no event.
  - sync==1 and dcnt==DEBOUNCE_CYCLES-1 → RELEASED, release_pulse=1, held=0.
  - Otherwise, dcnt increments.
- held is 1 in PRESSED and RELEASE_WAIT and 0 otherwise. It is registered.
- press_count adds the popcount of this cycle's press_pulse vector (0 to 3) using 8-bit wrapping arithmetic; 255 + 2 = 1.
- The three channels are fully independent. Simultaneous events on different keys are all reported in the same cycle.

## Timing
- All outputs are registered.
- Reset values: held=0, press_pulse=0, release_pulse=0, long_press=0, press_count=0. Every FSM is in RELEASED, counters are 0, synchronisers are 1.
- Reset assertion (KEY[0]=0) takes effect immediately, without waiting for a clock, in any state, including mid-debounce and mid-hold. Any pulse in flight is dropped.
- Reset deassertion is released on the next CLOCK_50 edge. A key already held low at release is treated as a fresh press and goes through the full debounce.
- Press latency: take edge 1 as the first rising edge that samples KEY[i]=0.
  - Edge 3: FSM enters PRESS_WAIT.
  - Edge DEBOUNCE_CYCLES+3: press_pulse is high for the cycle after this edge.
- Release latency is symmetric: DEBOUNCE_CYCLES+3 edges.
- long_press is high after the edge that is LONG_CYCLES edges past the press_pulse edge.
- A bounce shorter than DEBOUNCE_CYCLES stable cycles produces no pulse and restarts qualification.
- Pulses are exactly one cycle wide. Back-to-back presses are separated by at least 2·DEBOUNCE_CYCLES+2 cycles.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and LONG_CYCLES=20.
- Reset: hold KEY[0]=0 with KEY[3:1]=3'b111. All outputs must be 0. Releasing reset must not change any output.
- Clean press of KEY[1], held 10 cycles, then released: press_pulse[0] after edge 7 from the first low sample; held[0]=1; release_pulse[0] 7 edges after the first high sample; held[0]=0; press_count=1; no long_press.
- Bounce on KEY[2]: pattern low 2, high 1, low 2, high 5 cycles. No pulses, held[1] stays 0, press_count=0.
- Long press on KEY[3] for 40 cycles: press_pulse[2], then exactly one long_press[2] 20 edges later, then release_pulse[2] on release; held[2]=1 throughout.
- Simultaneous press of KEY[3:1] on the same edge, with press_count preset to 254 via 254 prior presses: all three press_pulse bits fire in the same cycle and press_count becomes 1.
- Reset mid-hold: assert KEY[0]=0 10 cycles into a press of KEY[1]. held[0] clears asynchronously, no release_pulse occurs, and press_count=0.
